// File: rtl/mips_debug_ctrl.sv
// UART-driven debug sequencer for the five-stage MIPS core: loads IMEM,
// runs or single-steps the pipeline, and dumps PC plus R0..R31 as 132 bytes.
module mips_debug_ctrl #(
  parameter int IMEM_AW      = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [7:0]         RxData,
  input  logic               RxValid,
  output logic [7:0]         TxData,
  output logic               TxStart,
  input  logic               TxBusy,
  output logic               PipeEnable,
  output logic               PipeReset,
  output logic               ImemWrEn,
  output logic [IMEM_AW-1:0] ImemWrAddr,
  output logic [31:0]        ImemWrData,
  input  logic               HaltSeen,
  input  logic [31:0]        PCResult,
  output logic [4:0]         DbgRegAddr,
  input  logic [31:0]        DbgRegData,
  output logic               Halted,
  output logic               Busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] RUN       = 3'd2;
  localparam logic [2:0] DRAIN     = 3'd3;
  localparam logic [2:0] STEP      = 3'd4;
  localparam logic [2:0] DUMP_SEND = 3'd5;
  localparam logic [2:0] DUMP_WAIT = 3'd6;

  localparam int         DCW       = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [7:0] LAST_BYTE = 8'd131;

  logic [2:0]         state;
  logic               halted;
  logic [IMEM_AW-1:0] wrAddr;
  logic [IMEM_AW-1:0] wrAddrQ;
  logic [31:0]        wrDataQ;
  logic               wrEnQ;
  logic [23:0]        wordBuf;
  logic [1:0]         byteCnt;
  logic               resetHold;
  logic [DCW-1:0]     drainCnt;
  logic [7:0]         byteIdx;
  logic [31:0]        shiftReg;
  logic               waitSkip;

  logic [5:0]         wordIdx;
  logic [31:0]        curWord;
  logic [7:0]         curByte;
  logic [31:0]        fullWord;
  logic               sendNow;

  // Word 0 of the dump is the PC; words 1..32 come from the register file.
  assign wordIdx  = byteIdx[7:2];
  assign curWord  = (wordIdx == 6'd0) ? PCResult : DbgRegData;
  assign curByte  = (byteIdx[1:0] == 2'd0) ? curWord[7:0] : shiftReg[7:0];
  assign fullWord = {RxData, wordBuf};
  assign sendNow  = (state == DUMP_SEND) && !TxBusy;

  always_comb begin
    // NOTE: assign a default before any condition so no path infers a latch.
    DbgRegAddr = 5'd0;
    if (wordIdx != 6'd0) DbgRegAddr = 5'(wordIdx - 6'd1);
  end

  assign TxStart    = sendNow;
  assign TxData     = sendNow ? curByte : 8'h00;
  assign PipeEnable = (state == RUN) || (state == STEP) ||
                      ((state == DRAIN) && (drainCnt != '0));
  // Pipeline reset covers LOAD plus one trailing cycle, and the reset period.
  assign PipeReset  = (state == LOAD) || resetHold;
  assign ImemWrEn   = wrEnQ;
  assign ImemWrAddr = wrAddrQ;
  assign ImemWrData = wrDataQ;
  assign Halted     = halted;
  assign Busy       = (state != IDLE);

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Reset) begin
      state     <= IDLE;
      halted    <= 1'b0;
      wrAddr    <= '0;
      wrAddrQ   <= '0;
      wrDataQ   <= '0;
      wrEnQ     <= 1'b0;
      wordBuf   <= '0;
      byteCnt   <= '0;
      resetHold <= 1'b1;
      drainCnt  <= '0;
      byteIdx   <= '0;
      shiftReg  <= '0;
      waitSkip  <= 1'b0;
    end else begin
      wrEnQ     <= 1'b0;
      resetHold <= (state == LOAD);
      case (state)
        IDLE: begin
          if (RxValid) begin
            case (RxData)
              8'h4C: begin
                state   <= LOAD;
                halted  <= 1'b0;
                wrAddr  <= '0;
                byteCnt <= '0;
              end
              8'h52:   state <= halted ? DUMP_SEND : RUN;
              8'h53:   state <= halted ? DUMP_SEND : STEP;
              8'h44:   state <= DUMP_SEND;
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (RxValid) begin
            byteCnt <= byteCnt + 2'd1;
            case (byteCnt)
              2'd0: wordBuf[7:0]   <= RxData;
              2'd1: wordBuf[15:8]  <= RxData;
              2'd2: wordBuf[23:16] <= RxData;
              default: begin
                wrEnQ   <= 1'b1;
                wrAddrQ <= wrAddr;
                wrDataQ <= fullWord;
                wrAddr  <= wrAddr + 1'b1;
                // A HALT word or the last address ends the load; never wrap.
                if (fullWord == 32'hFFFF_FFFF || wrAddr == '1) state <= IDLE;
              end
            endcase
          end
        end
        RUN: begin
          if (HaltSeen) begin
            state    <= DRAIN;
            drainCnt <= DCW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (drainCnt != '0) begin
            drainCnt <= drainCnt - 1'b1;
          end else begin
            halted <= 1'b1;
            state  <= DUMP_SEND;
          end
        end
        STEP: begin
          if (HaltSeen) halted <= 1'b1;
          state <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (!TxBusy) begin
            shiftReg <= (byteIdx[1:0] == 2'd0) ? {8'h00, curWord[31:8]}
                                               : {8'h00, shiftReg[31:8]};
            waitSkip <= 1'b1;
            state    <= DUMP_WAIT;
          end
        end
        DUMP_WAIT: begin
          // The first wait cycle is skipped because TxBusy lags TxStart by one.
          if (waitSkip) begin
            waitSkip <= 1'b0;
          end else if (!TxBusy) begin
            if (byteIdx == LAST_BYTE) begin
              byteIdx <= '0;
              state   <= IDLE;
            end else begin
              byteIdx <= byteIdx + 8'd1;
              state   <= DUMP_SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: small IMEM/PC/regfile/UART models
// with scoreboards for IMEM writes and dump bytes.
module tb_mips_debug_ctrl;

  localparam int AW = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [7:0]    RxData = 8'h00;
  logic          RxValid = 1'b0;
  logic [7:0]    TxData;
  logic          TxStart;
  logic          TxBusy;
  logic          PipeEnable;
  logic          PipeReset;
  logic          ImemWrEn;
  logic [AW-1:0] ImemWrAddr;
  logic [31:0]   ImemWrData;
  logic          HaltSeen;
  logic [31:0]   PCResult;
  logic [4:0]    DbgRegAddr;
  logic [31:0]   DbgRegData;
  logic          Halted;
  logic          Busy;

  mips_debug_ctrl #(.IMEM_AW(AW), .DRAIN_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .RxData(RxData), .RxValid(RxValid),
    .TxData(TxData), .TxStart(TxStart), .TxBusy(TxBusy),
    .PipeEnable(PipeEnable), .PipeReset(PipeReset),
    .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr), .ImemWrData(ImemWrData),
    .HaltSeen(HaltSeen), .PCResult(PCResult),
    .DbgRegAddr(DbgRegAddr), .DbgRegData(DbgRegData),
    .Halted(Halted), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Environment models: IMEM, PC that freezes on HALT, UART busy timer.
  logic [31:0] imem [0:3] = '{default: 32'h0};
  logic [31:0] pc = 32'h0;
  int          busyCnt = 0;
  int          busyLen = 2;

  always @(posedge Clock) begin
    if (ImemWrEn) imem[ImemWrAddr] <= ImemWrData;
    if (PipeReset) pc <= 32'h0;
    else if (PipeEnable && !HaltSeen) pc <= pc + 32'd4;
    if (TxStart) busyCnt <= busyLen;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end

  function automatic logic [31:0] regVal(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (r == 5'd5) return 32'hDEAD_BEEF;
    return {3'b0, r, 8'hA5, 3'b0, r, 8'h5A};
  endfunction

  assign HaltSeen   = (imem[pc[3:2]] == 32'hFFFF_FFFF);
  assign PCResult   = pc;
  assign TxBusy     = (busyCnt != 0);
  assign DbgRegData = regVal(DbgRegAddr);

  logic [7:0]  txQ [$];
  logic [33:0] wrQ [$];
  logic [7:0]  txLog [0:131];
  int nChecks = 0;
  int nPass = 0;
  int txCount = 0;
  int enCount = 0;
  int enAfterHalt = 0;
  int wrCount = 0;
  logic txPrev = 1'b0;
  logic haltPrev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic monitor();
    logic [8:0]  expByte;
    logic [34:0] expWr;
    forever begin
      @(negedge Clock);
      if (TxStart === 1'b1) begin
        check("txBackToBack", {63'h0, txPrev}, 64'h0);
        check("txWhileBusy", {63'h0, TxBusy}, 64'h0);
        expByte = (txQ.size() != 0) ? {1'b0, txQ.pop_front()} : 9'h100;
        check($sformatf("txByte%0d", txCount), {55'h0, 1'b0, TxData}, {55'h0, expByte});
        if (txCount < 132) txLog[txCount] = TxData;
        txCount++;
      end
      txPrev = (TxStart === 1'b1);
      if (ImemWrEn === 1'b1) begin
        expWr = (wrQ.size() != 0) ? {1'b0, wrQ.pop_front()} : 35'h4_0000_0000;
        check($sformatf("imemWrite%0d", wrCount), {29'h0, 1'b0, ImemWrAddr, ImemWrData},
              {29'h0, expWr});
        check("pipeResetDuringLoad", {63'h0, PipeReset}, 64'h1);
        wrCount++;
      end
      if (PipeEnable === 1'b1) begin
        enCount++;
        if (haltPrev) enAfterHalt++;
      end
      haltPrev = (HaltSeen === 1'b1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge Clock);
    #1 RxData = b;
    RxValid = 1'b1;
    @(posedge Clock);
    #1 RxValid = 1'b0;
    RxData = 8'h00;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit expWrite, input logic [1:0] addr);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expWrite) wrQ.push_back({addr, w});
      sendByte(w[8*i +: 8]);
    end
  endtask

  task automatic pushDump(input logic [31:0] pcExp);
    logic [31:0] word;
    for (int w = 0; w < 33; w++) begin
      word = (w == 0) ? pcExp : regVal(5'(w - 1));
      for (int b = 0; b < 4; b++) txQ.push_back(word[8*b +: 8]);
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int n = 0; n < budget && Busy; n++) @(negedge Clock);
    check(tag, {63'h0, Busy}, 64'h0);
  endtask

  task automatic checkDumpDone(input string tag);
    check({tag, "Bytes"}, txCount, 132);
    check({tag, "Leftover"}, txQ.size(), 0);
  endtask

  task automatic doReset();
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int txSnap, enSnap, wrSnap;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(posedge Clock);
    #1;
    check("rstPipeReset", {63'h0, PipeReset}, 64'h1);
    check("rstPipeEnable", {63'h0, PipeEnable}, 64'h0);
    check("rstTxStart", {63'h0, TxStart}, 64'h0);
    check("rstTxData", {56'h0, TxData}, 64'h0);
    check("rstImemWrEn", {63'h0, ImemWrEn}, 64'h0);
    check("rstImemWrAddr", {62'h0, ImemWrAddr}, 64'h0);
    check("rstImemWrData", {32'h0, ImemWrData}, 64'h0);
    check("rstDbgRegAddr", {59'h0, DbgRegAddr}, 64'h0);
    check("rstHalted", {63'h0, Halted}, 64'h0);
    check("rstBusy", {63'h0, Busy}, 64'h0);
    Reset = 1'b0;
    tick(1);
    check("pipeResetReleased", {63'h0, PipeReset}, 64'h0);

    // Load: one instruction then HALT
    sendByte(8'h4C);
    check("loadBusy", {63'h0, Busy}, 64'h1);
    check("loadPipeReset", {63'h0, PipeReset}, 64'h1);
    sendWord(32'h2008_0000, 1'b1, 2'd0);
    sendWord(32'hFFFF_FFFF, 1'b1, 2'd1);
    check("loadTrailingPipeReset", {63'h0, PipeReset}, 64'h1);
    tick(1);
    check("loadBackIdle", {63'h0, Busy}, 64'h0);
    check("loadWrites", wrCount, 2);
    tick(1);
    check("loadPipeResetDrops", {63'h0, PipeReset}, 64'h0);

    // Address wrap ends the load; a fifth word is not written
    sendByte(8'h4C);
    sendWord(32'h2008_0000, 1'b1, 2'd0);
    sendWord(32'h2009_0001, 1'b1, 2'd1);
    sendWord(32'h012A_5020, 1'b1, 2'd2);
    sendWord(32'h0000_0000, 1'b1, 2'd3);
    tick(1);
    check("wrapBackIdle", {63'h0, Busy}, 64'h0);
    sendWord(32'h0102_0309, 1'b0, 2'd0);
    tick(3);
    check("wrapWrites", wrCount, 6);
    check("wrapQueueEmpty", wrQ.size(), 0);

    // Program with HALT at word 3
    sendByte(8'h4C);
    sendWord(32'h2008_0000, 1'b1, 2'd0);
    sendWord(32'h2009_0001, 1'b1, 2'd1);
    sendWord(32'h012A_5020, 1'b1, 2'd2);
    sendWord(32'hFFFF_FFFF, 1'b1, 2'd3);
    tick(2);
    check("progWrites", wrCount, 10);
    check("progHaltedClear", {63'h0, Halted}, 64'h0);

    // Single step: one enable, PC advances by one word, then dump
    enCount = 0;
    txCount = 0;
    pushDump(32'd4);
    sendByte(8'h53);
    waitIdle("stepDumpDone", 2000);
    check("stepEnables", enCount, 1);
    check("stepNotHalted", {63'h0, Halted}, 64'h0);
    checkDumpDone("step");

    // Run to HALT, drain four cycles, then dump
    enCount = 0;
    enAfterHalt = 0;
    txCount = 0;
    pushDump(32'd12);
    sendByte(8'h52);
    waitIdle("runDumpDone", 3000);
    check("drainEnables", enAfterHalt, 4);
    check("runEnables", enCount, 7);
    check("runHalted", {63'h0, Halted}, 64'h1);
    check("runPcBytes", {32'h0, txLog[3], txLog[2], txLog[1], txLog[0]}, 64'd12);
    checkDumpDone("run");

    // Step while halted: dump only
    enCount = 0;
    txCount = 0;
    pushDump(32'd12);
    sendByte(8'h53);
    waitIdle("haltedStepDone", 2000);
    check("haltedStepEnables", enCount, 0);
    checkDumpDone("haltedStep");

    // Slow transmitter handshake
    busyLen = 20;
    txCount = 0;
    pushDump(32'd12);
    sendByte(8'h44);
    waitIdle("slowDumpDone", 6000);
    check("r5Bytes", {32'h0, txLog[27], txLog[26], txLog[25], txLog[24]}, 64'hDEAD_BEEF);
    checkDumpDone("slow");
    busyLen = 2;

    // Reset while running a program without HALT
    sendByte(8'h4C);
    sendWord(32'h2008_0000, 1'b1, 2'd0);
    sendWord(32'h2009_0001, 1'b1, 2'd1);
    sendWord(32'h012A_5020, 1'b1, 2'd2);
    sendWord(32'h0000_0000, 1'b1, 2'd3);
    tick(2);
    sendByte(8'h52);
    tick(10);
    check("runActive", {63'h0, PipeEnable}, 64'h1);
    doReset();
    check("midRunPipeEnable", {63'h0, PipeEnable}, 64'h0);
    check("midRunBusy", {63'h0, Busy}, 64'h0);
    check("midRunPipeReset", {63'h0, PipeReset}, 64'h1);

    // Reset in the middle of a dump
    tick(2);
    txCount = 0;
    pushDump(32'd0);
    sendByte(8'h44);
    tick(40);
    check("dumpInProgress", {63'h0, Busy}, 64'h1);
    doReset();
    txQ.delete();
    check("midDumpTxStart", {63'h0, TxStart}, 64'h0);
    check("midDumpBusy", {63'h0, Busy}, 64'h0);
    check("midDumpPipeEnable", {63'h0, PipeEnable}, 64'h0);

    // Unknown command byte does nothing
    tick(25);
    txSnap = txCount;
    enSnap = enCount;
    wrSnap = wrCount;
    sendByte(8'h41);
    check("unknownBusy", {63'h0, Busy}, 64'h0);
    tick(20);
    check("unknownTx", txCount, txSnap);
    check("unknownEnable", enCount, enSnap);
    check("unknownWrite", wrCount, wrSnap);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
